// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers (MULT/DIV, MFHI/MFLO/MTHI/MTLO).
// Define MULDIV_SIGNED_EN to honour SignedE; otherwise every operation is unsigned.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartMultE,
  input  logic             StartDivE,
  input  logic             SignedE,
  input  logic             MthiE,
  input  logic             MtloE,
  input  logic             MfhiE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic [WIDTH-1:0] HiLoOutE,
  output logic             BusyE
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        count_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     opb_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q;
  logic                 rneg_q;
  logic                 divz_q;

  logic                 signed_op_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_sh_s;
  logic [WIDTH-1:0]     div_sub_s;
  logic                 div_ge_s;
  logic [2*WIDTH-1:0]   step_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     res_hi_s;
  logic [WIDTH-1:0]     res_lo_s;

`ifdef MULDIV_SIGNED_EN
  assign signed_op_s = SignedE;
`else
  logic unused_signed_s;
  assign unused_signed_s = SignedE;
  assign signed_op_s     = 1'b0;
`endif

  // The iteration always runs on magnitudes; signs are folded back in on the last edge.
  assign a_neg_s = signed_op_s & SrcAE[WIDTH-1];
  assign b_neg_s = signed_op_s & SrcBE[WIDTH-1];
  assign a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - SrcAE) : SrcAE;
  assign b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - SrcBE) : SrcBE;

  assign BusyE    = (state_q != IDLE);
  assign HiLoOutE = MfhiE ? hi_q : lo_q;

  // One shift-add or restoring-divide step on the accumulator.
  always_comb begin
    mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_sh_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_s  = (div_sh_s >= {1'b0, opb_q});
    div_sub_s = div_sh_s[WIDTH-1:0] - opb_q;
    case (state_q)
      MUL: step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
      DIV: begin
        if (div_ge_s) begin
          step_s = {div_sub_s, acc_q[WIDTH-2:0], 1'b1};
        end else begin
          step_s = {div_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end
      default: step_s = acc_q;
    endcase
  end

  // Final HI/LO values with sign fixup and the divide-by-zero quotient rule.
  always_comb begin
    prod_s = neg_q ? ({(2*WIDTH){1'b0}} - step_s) : step_s;
    quo_s  = step_s[WIDTH-1:0];
    rem_s  = step_s[2*WIDTH-1:WIDTH];
    if (state_q == DIV) begin
      res_hi_s = rneg_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;
      if (divz_q) begin
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_lo_s = neg_q ? ({WIDTH{1'b0}} - quo_s) : quo_s;
      end
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, operand latching, iteration and HI/LO updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (StartMultE) begin
            state_q <= MUL;
            acc_q   <= {{WIDTH{1'b0}}, a_mag_s};
            opb_q   <= b_mag_s;
            neg_q   <= a_neg_s ^ b_neg_s;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
          end else if (StartDivE) begin
            state_q <= DIV;
            acc_q   <= {{WIDTH{1'b0}}, a_mag_s};
            opb_q   <= b_mag_s;
            neg_q   <= a_neg_s ^ b_neg_s;
            rneg_q  <= a_neg_s;
            divz_q  <= (SrcBE == {WIDTH{1'b0}});
          end else begin
            if (MthiE) begin
              hi_q <= SrcAE;
            end else begin
              hi_q <= hi_q;
            end
            if (MtloE) begin
              lo_q <= SrcAE;
            end else begin
              lo_q <= lo_q;
            end
          end
        end
        MUL, DIV: begin
          acc_q <= step_s;
          if (count_q == CNT_LAST) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= res_hi_s;
            lo_q    <= res_lo_s;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed table, MT/reset corner sequences, and random ops vs. an arithmetic model.
// Expectations follow MULDIV_SIGNED_EN when it is defined for the build.
module tb_ex_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         StartMultE, StartDivE, SignedE, MthiE, MtloE, MfhiE;
  logic [W-1:0] SrcAE, SrcBE, HiLoOutE;
  logic         BusyE;

  int n_vec = 0;
  int n_bad = 0;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .StartMultE(StartMultE), .StartDivE(StartDivE),
    .SignedE(SignedE), .MthiE(MthiE), .MtloE(MtloE), .MfhiE(MfhiE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .HiLoOutE(HiLoOutE), .BusyE(BusyE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          mul;
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MfhiE = 1'b1; #1; hi = HiLoOutE;
    MfhiE = 1'b0; #1; lo = HiLoOutE;
  endtask

  // Waits (bounded) for BusyE to drop, scrambling operands while busy; returns busy cycle count.
  task automatic wait_idle(output int busy);
    busy = 0;
    while (BusyE && busy < 100) begin
      busy++;
      @(posedge clk); #1;
      SrcAE = $urandom; SrcBE = $urandom; SignedE = 1'($urandom);
    end
  endtask

  task automatic run_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, output int busy);
    @(negedge clk);
    StartMultE = mul; StartDivE = !mul; SignedE = sgn; SrcAE = a; SrcBE = b;
    @(posedge clk); #1;
    StartMultE = 1'b0; StartDivE = 1'b0;
    wait_idle(busy);
  endtask

  function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                input bit sgn, output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    int sa, sb;
    bit s = sgn;
`ifndef MULDIV_SIGNED_EN
    s = 1'b0;
`endif
    if (mul) begin
      if (s) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else   p = {32'd0, a} * {32'd0, b};
      hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000; hi = 32'd0;
      end else begin
        sa = a; sb = b;
        lo = sa / sb; hi = sa % sb;
      end
    end else begin
      lo = a / b; hi = a % b;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [5];
    edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 255));
      1:       return edges[$urandom_range(0, 4)];
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl [7];
  logic [31:0] hi, lo, hi_prev, exp_hi, exp_lo;
  int          busy;

  initial begin
    tbl[0] = '{"multu_max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{"divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14};
    tbl[2] = '{"divu_by0", 1'b0, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF};
    tbl[3] = '{"multu_3_4", 1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12};
`ifdef MULDIV_SIGNED_EN
    tbl[4] = '{"mult_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[5] = '{"div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[6] = '{"div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000};
`else
    tbl[4] = '{"mult_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1};
    tbl[5] = '{"div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC};
    tbl[6] = '{"div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
`endif

    rst = 1'b1; StartMultE = 1'b0; StartDivE = 1'b0; SignedE = 1'b0;
    MthiE = 1'b0; MtloE = 1'b0; MfhiE = 1'b0; SrcAE = '0; SrcBE = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    check("reset_busy", {31'd0, BusyE}, 32'd0);
    read_hilo(hi, lo);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].mul, tbl[i].a, tbl[i].b, tbl[i].sgn, busy);
      read_hilo(hi, lo);
      check({tbl[i].name, "_busy"}, busy, 32'd32);
      check({tbl[i].name, "_hi"}, hi, tbl[i].hi);
      check({tbl[i].name, "_lo"}, lo, tbl[i].lo);
    end

    // MTHI then MFHI
    @(negedge clk); MthiE = 1'b1; SrcAE = 32'h1234;
    @(posedge clk); #1; MthiE = 1'b0;
    read_hilo(hi, lo);
    check("mthi_mfhi", hi, 32'h1234);

    // MTLO seeds LO; MTHI/MTLO issued while busy must be ignored
    @(negedge clk); MtloE = 1'b1; SrcAE = 32'h55;
    @(posedge clk); #1; MtloE = 1'b0;
    read_hilo(hi_prev, lo);
    check("mtlo_seed", lo, 32'h55);
    @(negedge clk); StartMultE = 1'b1; SrcAE = 32'd3; SrcBE = 32'd4;
    @(posedge clk); #1; StartMultE = 1'b0;
    @(negedge clk); MtloE = 1'b1; MthiE = 1'b1; SrcAE = 32'hBAD0_BAD0;
    @(posedge clk); #1; MtloE = 1'b0; MthiE = 1'b0;
    read_hilo(hi, lo);
    check("mtlo_busy_lo", lo, 32'h55);
    check("mthi_busy_hi", hi, hi_prev);
    wait_idle(busy);
    read_hilo(hi, lo);
    check("after_busy_lo", lo, 32'd12);

    // Start and MTLO in the same cycle: only the product lands
    @(negedge clk); StartMultE = 1'b1; MtloE = 1'b1; SrcAE = 32'd6; SrcBE = 32'd7;
    @(posedge clk); #1; StartMultE = 1'b0; MtloE = 1'b0;
    wait_idle(busy);
    read_hilo(hi, lo);
    check("start_mtlo_lo", lo, 32'd42);
    check("start_mtlo_hi", hi, 32'd0);

    // Both starts: multiply wins
    @(negedge clk); StartMultE = 1'b1; StartDivE = 1'b1; SignedE = 1'b0; SrcAE = 32'd100; SrcBE = 32'd7;
    @(posedge clk); #1; StartMultE = 1'b0; StartDivE = 1'b0;
    wait_idle(busy);
    read_hilo(hi, lo);
    check("both_start_lo", lo, 32'd700);
    check("both_start_busy", busy, 32'd32);

    // MTHI and MTLO together
    @(negedge clk); MthiE = 1'b1; MtloE = 1'b1; SrcAE = 32'hA5A5_0F0F;
    @(posedge clk); #1; MthiE = 1'b0; MtloE = 1'b0;
    read_hilo(hi, lo);
    check("mt_both_hi", hi, 32'hA5A5_0F0F);
    check("mt_both_lo", lo, 32'hA5A5_0F0F);

    // Reset at cycle 10 of a multiply aborts without a partial result
    @(negedge clk); StartMultE = 1'b1; SrcAE = 32'hFFFF_FFFF; SrcBE = 32'h1234_5678;
    @(posedge clk); #1; StartMultE = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rst_mid_busy", {31'd0, BusyE}, 32'd0);
    read_hilo(hi, lo);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    run_op(1'b1, 32'd3, 32'd4, 1'b0, busy);
    read_hilo(hi, lo);
    check("post_rst_lo", lo, 32'd12);
    check("post_rst_busy", busy, 32'd32);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      bit          r_mul, r_sgn;
      logic [31:0] ra, rb;
      r_mul = 1'($urandom);
      r_sgn = 1'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      model(r_mul, ra, rb, r_sgn, exp_hi, exp_lo);
      run_op(r_mul, ra, rb, r_sgn, busy);
      read_hilo(hi, lo);
      check("rand_busy", busy, 32'd32);
      check("rand_hi", hi, exp_hi);
      check("rand_lo", lo, exp_lo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
